imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 128-word, combinational-read instruction memory.
- Owns the program counter and drives the memory word address. Registers each fetched word into a one-entry output slot with a valid/ready handshake toward decode.
- Handles branch/jump redirects, EBREAK halt and bad-redirect error.
- Sits between the instruction memory and the decode stage.

Parameters:
- ADDR_W, 7, word-address width of instruction memory (depth 2**ADDR_W).
- RESET_PC, 32'h0000_0000, byte PC loaded on reset and on start.
- HALT_INSTR, 32'h0010_0073, encoding that halts fetch (EBREAK).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  pulse; begins fetching from RESET_PC when IDLE or HALTED.
- imem_addr  output  ADDR_W  word address to instruction memory.
- imem_instr  input  32  instruction word returned combinationally for imem_addr.
- if_valid  output  1  output slot holds a valid instruction.
- if_ready  input  1  decode accepts slot this cycle.
- if_instr  output  32  instruction in slot.
- if_pc  output  32  byte PC of if_instr, zero-extended.
- redirect_valid  input  1  redirect fetch to redirect_pc.
- redirect_pc  input  32  target byte address.
- busy  output  1  state is FETCH.
- halted  output  1  state is HALTED.
- err  output  1  sticky; set on an illegal redirect, cleared by reset or start.
- fetch_count  output  32  number of instructions accepted by decode (if_valid & if_ready).

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, pc=RESET_PC, slot empty.
  - Outputs: if_valid=0, if_instr=0, if_pc=0, imem_addr=0, busy=0, halted=0, err=0, fetch_count=0.
- pc is an internal (ADDR_W+2)-bit byte address.
  - imem_addr = pc[ADDR_W+1:2], driven combinationally from the pc register.
  - pc increment wraps modulo 2**(ADDR_W+2); 0x1FC+4 -> 0x000.
- Handshake: an instruction is accepted when if_valid & if_ready.
  - if_instr and if_pc hold stable while if_valid=1 and not accepted.
  - fetch_count increments by 1 per acceptance and wraps at 2**32.
- "load" condition: state FETCH and (slot empty or acceptance this cycle) and no redirect.
- On load:
  - Slot <= {imem_instr, pc}; if_valid<=1; pc<=pc+4.
  - Load-to-visible latency: 1 cycle. Back-to-back throughput: 1 instruction/cycle while if_ready=1.
- States:
  - IDLE: nothing fetched. start -> FETCH, pc<=RESET_PC, err<=0.
  - FETCH: loads as above.
    - If the loaded word equals HALT_INSTR, it is still placed in the slot and the state goes to HALTED in the same edge; pc is not advanced.
  - HALTED: no new loads. The slot drains normally via the handshake (the halt instruction is delivered).
    - start -> FETCH, pc<=RESET_PC, slot flushed, err<=0.
- Redirect (redirect_valid=1, any state except IDLE):
  - Highest priority over load.
  - The slot is flushed (if_valid<=0) even if an acceptance happens the same cycle; that acceptance still counts in fetch_count.
  - Legal target (redirect_pc[1:0]==0 and redirect_pc[31:ADDR_W+2]==0): pc<=redirect_pc[ADDR_W+1:0], state<=FETCH. This includes leaving HALTED.
  - First redirected instruction is visible 2 cycles after the redirect cycle.
  - Illegal target: err<=1, state<=HALTED, pc unchanged, slot flushed.
  - redirect_valid in IDLE is ignored.
- Simultaneous events:
  - start and redirect_valid in the same cycle: start wins.
  - start in FETCH is ignored.
- Reset mid-operation: immediate return to the reset values; no partial handshake is completed.

Decomposition:
- Shared package rv_fetch_pkg:
  - State enum (IDLE, FETCH, HALTED).
  - Constants: NOP 32'h0000_0013, EBREAK 32'h0010_0073, RESET_PC.
- One natural sub-module: fetch_slot, a one-entry valid/ready register holding {instr, pc} with flush and load inputs.
- The PC/FSM logic stays in imem_fetch_ctrl.

Test Plan:
- Reset then start, memory = {0:00000013, 1:00100093, 2:00200113, 3:00308193}, if_ready=1 -> if_instr 00000013/00100093/00200113/00308193 on consecutive cycles; if_pc 0,4,8,C; fetch_count=4 after last acceptance.
- Same program with if_ready=0 for 3 cycles while holding 00100093 -> if_instr and if_pc=4 stable; imem_addr stays 2; on release the next instruction is 00200113 at pc 8, none skipped or duplicated.
- Redirect to 0x0C while the slot holds pc 4 and if_ready=1 -> pc 4 counted, slot flushed next cycle; 00308193 at if_pc=0x0C appears 2 cycles after the redirect.
- Word 5 = 00100073 -> delivered with if_pc=0x14, then halted=1, busy=0, if_valid=0 after acceptance; start -> fetch resumes at pc 0.
- Redirect to 0x0000_0006, then separately to 0x0000_0200 -> each sets err=1 and halted=1 with slot flushed; start clears err.
- Memory filled with NOPs, free-run from pc 0x1F8 -> if_pc sequence 0x1F8, 0x1FC, 0x000; rst_n low mid-stream -> if_valid=0 and fetch_count=0 immediately (async).

Source files
------------

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Holds the fetch FSM state encoding and well-known RV32I instruction words.
package rv_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HALTED
    } fetch_state_e;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // A redirect target must be word aligned and lie inside the memory.
    function automatic logic redirect_legal(input logic [31:0] target,
                                            input int unsigned pc_w);
        return (target[1:0] == 2'b00) && ((target >> pc_w) == 32'h0);
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_slot.sv
// One-entry valid/ready output register holding a fetched {instr, pc} pair.
// Flush beats load, load beats a plain drain.
module fetch_slot #(
    parameter int unsigned PC_W = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            load_i,
    input  logic [31:0]     instr_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic            ready_i,
    output logic            valid_o,
    output logic [31:0]     instr_o,
    output logic [PC_W-1:0] pc_o,
    output logic            accept_o
);

    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] pc_q, pc_d;

    assign accept_o = valid_q & ready_i;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (accept_o) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational instruction
// memory and hands words to decode through a one-entry valid/ready slot.
module imem_fetch_ctrl
    import rv_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W     = 7,
    parameter logic [31:0] RESET_PC   = rv_fetch_pkg::RESET_PC,
    parameter logic [31:0] HALT_INSTR = rv_fetch_pkg::EBREAK
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_instr,
    output logic [31:0]       if_pc,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic [31:0]       fetch_count
);

    localparam int unsigned PC_W = ADDR_W + 2;

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            err_q, err_d;
    logic [31:0]     fetch_count_q, fetch_count_d;

    logic            slot_valid;
    logic            slot_accept;
    logic [PC_W-1:0] slot_pc;
    logic            load;
    logic            flush;
    logic            start_go;
    logic            redir;

    // start only acts outside FETCH, and where it acts it overrides a redirect.
    assign start_go = start && (state_q != ST_FETCH);
    assign redir    = redirect_valid && (state_q != ST_IDLE) && !start_go;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        load    = 1'b0;
        flush   = 1'b0;
        if (start_go) begin
            state_d = ST_FETCH;
            pc_d    = RESET_PC[PC_W-1:0];
            err_d   = 1'b0;
            flush   = 1'b1;
        end else if (redir) begin
            flush = 1'b1;
            if (redirect_legal(redirect_pc, PC_W)) begin
                pc_d    = redirect_pc[PC_W-1:0];
                state_d = ST_FETCH;
            end else begin
                err_d   = 1'b1;
                state_d = ST_HALTED;
            end
        end else if ((state_q == ST_FETCH) && (!slot_valid || slot_accept)) begin
            load = 1'b1;
            // The halt word is still delivered, but the PC parks on it.
            if (imem_instr == HALT_INSTR) begin
                state_d = ST_HALTED;
            end else begin
                pc_d = pc_q + PC_W'(4);
            end
        end
    end

    assign fetch_count_d = slot_accept ? fetch_count_q + 32'd1 : fetch_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC[PC_W-1:0];
            err_q         <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            err_q         <= err_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    fetch_slot #(
        .PC_W(PC_W)
    ) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush),
        .load_i   (load),
        .instr_i  (imem_instr),
        .pc_i     (pc_q),
        .ready_i  (if_ready),
        .valid_o  (slot_valid),
        .instr_o  (if_instr),
        .pc_o     (slot_pc),
        .accept_o (slot_accept)
    );

    assign imem_addr   = pc_q[PC_W-1:2];
    assign if_valid    = slot_valid;
    assign if_pc       = {{(32-PC_W){1'b0}}, slot_pc};
    assign busy        = (state_q == ST_FETCH);
    assign halted      = (state_q == ST_HALTED);
    assign err         = err_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: per-cycle vector table plus
// hand-written halt/error/wrap/reset sequences, with a delivery scoreboard.
module tb_imem_fetch_ctrl;
    import rv_fetch_pkg::*;

    localparam int unsigned AW = 7;
    localparam logic [31:0] I1 = 32'h0010_0093;
    localparam logic [31:0] I2 = 32'h0020_0113;
    localparam logic [31:0] I3 = 32'h0030_8193;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_instr;
    logic          if_valid;
    logic          if_ready;
    logic [31:0]   if_instr;
    logic [31:0]   if_pc;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          busy;
    logic          halted;
    logic          err;
    logic [31:0]   fetch_count;

    logic [31:0] mem [128];

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr];

    imem_fetch_ctrl #(
        .ADDR_W    (AW),
        .RESET_PC  (32'h0000_0000),
        .HALT_INSTR(EBREAK)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .busy          (busy),
        .halted        (halted),
        .err           (err),
        .fetch_count   (fetch_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    // ctl = {start, if_ready, redirect_valid}; flags = {if_valid, busy, halted, err}
    typedef struct {
        logic [2:0]  ctl;
        logic [31:0] rpc;
        logic [3:0]  flags;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [6:0]  e_addr;
        logic [31:0] e_cnt;
    } vec_t;

    exp_t        sb[$];
    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        sb.push_back(e);
    endtask

    task automatic cyc(input logic [2:0] ctl, input logic [31:0] rpc);
        start          = ctl[2];
        if_ready       = ctl[1];
        redirect_valid = ctl[0];
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input string tag, input logic [3:0] flags,
                              input logic [6:0] addr, input logic [31:0] cnt);
        chk({tag, "_flags"}, 32'({if_valid, busy, halted, err}), 32'(flags));
        chk({tag, "_addr"}, 32'(imem_addr), 32'(addr));
        chk({tag, "_count"}, fetch_count, cnt);
    endtask

    task automatic chk_slot(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        chk({tag, "_pc"}, if_pc, pc);
        chk({tag, "_instr"}, if_instr, instr);
    endtask

    // Every handshake the DUT will complete at the next rising edge is checked
    // against the oldest expected delivery.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && if_valid && if_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_underflow: got pc %h instr %h expected no delivery", if_pc, if_instr);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", if_pc, e.pc);
                chk("sb_instr", if_instr, e.instr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "timeout");
    end

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{3'b110, 32'h0,  4'b0100, 32'h0,  32'h0, 7'd0, 32'd0};
        vecs[1]  = '{3'b010, 32'h0,  4'b1100, 32'h0,  NOP,   7'd1, 32'd0};
        vecs[2]  = '{3'b010, 32'h0,  4'b1100, 32'h4,  I1,    7'd2, 32'd1};
        vecs[3]  = '{3'b000, 32'h0,  4'b1100, 32'h4,  I1,    7'd2, 32'd1};
        vecs[4]  = '{3'b100, 32'h0,  4'b1100, 32'h4,  I1,    7'd2, 32'd1};
        vecs[5]  = '{3'b000, 32'h0,  4'b1100, 32'h4,  I1,    7'd2, 32'd1};
        vecs[6]  = '{3'b010, 32'h0,  4'b1100, 32'h8,  I2,    7'd3, 32'd2};
        vecs[7]  = '{3'b010, 32'h0,  4'b1100, 32'hC,  I3,    7'd4, 32'd3};
        vecs[8]  = '{3'b010, 32'h0,  4'b1100, 32'h10, NOP,   7'd5, 32'd4};
        vecs[9]  = '{3'b001, 32'h0,  4'b0100, 32'h0,  32'h0, 7'd0, 32'd4};
        vecs[10] = '{3'b000, 32'h0,  4'b1100, 32'h0,  NOP,   7'd1, 32'd4};
        vecs[11] = '{3'b010, 32'h0,  4'b1100, 32'h4,  I1,    7'd2, 32'd5};
        vecs[12] = '{3'b011, 32'hC,  4'b0100, 32'h0,  32'h0, 7'd3, 32'd6};
        vecs[13] = '{3'b010, 32'h0,  4'b1100, 32'hC,  I3,    7'd4, 32'd6};
        vecs[14] = '{3'b000, 32'h0,  4'b1100, 32'hC,  I3,    7'd4, 32'd6};

        for (int unsigned i = 0; i < 128; i++) mem[i] = NOP;
        mem[1] = I1;
        mem[2] = I2;
        mem[3] = I3;
        mem[5] = EBREAK;

        rst_n          = 1'b0;
        start          = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_status("reset", 4'b0000, 7'd0, 32'd0);
        chk_slot("reset", 32'h0, 32'h0);
        rst_n = 1'b1;

        cyc(3'b001, 32'h40);
        chk_status("idle_redirect", 4'b0000, 7'd0, 32'd0);

        push(32'h0, NOP);
        push(32'h4, I1);
        push(32'h8, I2);
        push(32'hC, I3);
        push(32'h0, NOP);
        push(32'h4, I1);
        for (int unsigned i = 0; i < 15; i++) begin
            cyc(vecs[i].ctl, vecs[i].rpc);
            chk_status($sformatf("row%0d", i), vecs[i].flags, vecs[i].e_addr, vecs[i].e_cnt);
            if (vecs[i].flags[3]) chk_slot($sformatf("row%0d", i), vecs[i].e_pc, vecs[i].e_instr);
        end

        push(32'hC, I3);
        push(32'h10, NOP);
        push(32'h14, EBREAK);
        cyc(3'b010, 32'h0);
        chk_status("pre_halt", 4'b1100, 7'd5, 32'd7);
        chk_slot("pre_halt", 32'h10, NOP);
        cyc(3'b010, 32'h0);
        chk_status("halt_load", 4'b1010, 7'd5, 32'd8);
        chk_slot("halt_load", 32'h14, EBREAK);
        cyc(3'b010, 32'h0);
        chk_status("halt_drained", 4'b0010, 7'd5, 32'd9);
        cyc(3'b010, 32'h0);
        chk_status("halt_hold", 4'b0010, 7'd5, 32'd9);

        cyc(3'b100, 32'h0);
        chk_status("restart", 4'b0100, 7'd0, 32'd9);
        cyc(3'b000, 32'h0);
        chk_status("restart_load", 4'b1100, 7'd1, 32'd9);
        chk_slot("restart_load", 32'h0, NOP);

        cyc(3'b001, 32'h6);
        chk_status("bad_align", 4'b0011, 7'd1, 32'd9);
        cyc(3'b100, 32'h0);
        chk_status("err_clear1", 4'b0100, 7'd0, 32'd9);
        cyc(3'b001, 32'h200);
        chk_status("bad_range", 4'b0011, 7'd0, 32'd9);
        cyc(3'b101, 32'h40);
        chk_status("start_wins", 4'b0100, 7'd0, 32'd9);

        push(32'h1F8, NOP);
        push(32'h1FC, NOP);
        cyc(3'b011, 32'h1F8);
        chk_status("wrap_redir", 4'b0100, 7'd126, 32'd9);
        cyc(3'b010, 32'h0);
        chk_status("wrap0", 4'b1100, 7'd127, 32'd9);
        chk_slot("wrap0", 32'h1F8, NOP);
        cyc(3'b010, 32'h0);
        chk_status("wrap1", 4'b1100, 7'd0, 32'd10);
        chk_slot("wrap1", 32'h1FC, NOP);
        cyc(3'b010, 32'h0);
        chk_status("wrap2", 4'b1100, 7'd1, 32'd11);
        chk_slot("wrap2", 32'h0, NOP);

        rst_n = 1'b0;
        #1;
        chk_status("async_reset", 4'b0000, 7'd0, 32'd0);
        chk_slot("async_reset", 32'h0, 32'h0);
        chk("sb_left", 32'(sb.size()), 32'd0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
